ips2l_expd_apb_mux_nch: RTL and testbench
=========================================

Name: ips2l_expd_apb_mux_nch

Overview:
Parametrised N-slave APB address-decode mux for the expansion register space. It replaces fixed two-way nibble decoding with a table-driven decode over a configurable address field. Transactions are registered and tracked by an FSM, with per-access timeout, decode-miss error response and saturating error counters. It sits in a single clock domain behind the APB clock-domain crossing and fans out to DMA, CFG and future register slaves.

Parameters:
NUM_SLV, 4, number of downstream slaves (1..16)
ADDR_W, 16, APB address width
DATA_W, 32, APB data width
DEC_MSB, 15, MSB of the decode field in i_p_addr
DEC_LSB, 12, LSB of the decode field; field width DW = DEC_MSB-DEC_LSB+1
SLV_BASE, {4'hB,4'hA,4'h9,4'h8}, packed NUM_SLV*DW vector; slave k matches when the field equals SLV_BASE[k*DW +: DW]
TIMEOUT, 255, cycles in ACCESS without slave rdy before an error response (must fit 8 bits, must be ≥1)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error response

Ports:
i_clk  in  1  block clock
i_rst  in  1  reset; asynchronous, active-high
i_p_sel  in  1  upstream select
i_p_strb  in  DATA_W/8  upstream byte strobes
i_p_addr  in  ADDR_W  upstream address
i_p_wdata  in  DATA_W  upstream write data
i_p_ce  in  1  upstream access enable
i_p_we  in  1  upstream write enable
o_p_rdy  out  1  registered one-cycle transfer-done pulse
o_p_rdata  out  DATA_W  registered read data, valid with o_p_rdy
o_p_err  out  1  error qualifier, valid with o_p_rdy
o_slv_p_sel  out  NUM_SLV  one-hot per-slave select
o_slv_p_strb / o_slv_p_addr / o_slv_p_wdata / o_slv_p_ce / o_slv_p_we  out  as upstream  shared buses, combinational copies of the upstream inputs
i_slv_p_rdy  in  NUM_SLV  per-slave ready
i_slv_p_rdata  in  NUM_SLV*DATA_W  per-slave read data, slave k at [k*DATA_W +: DATA_W]
o_miss_cnt  out  8  saturating count of decode misses
o_tout_cnt  out  8  saturating count of timeouts

Behaviour:
- Reset state:
  - FSM in IDLE.
  - o_p_rdy, o_p_err and o_slv_p_sel are 0.
  - o_p_rdata, both counters and the index register are 0.
  - Reset asserted mid-access drops all slave selects immediately (asynchronously). No response is issued.
- Decode:
  - Lowest-index matching slave wins.
  - No match means a miss.
- FSM states and transitions:
  - IDLE: on i_p_sel=1, register the decoded index and the hit flag and clear the timeout counter. On a hit, go to ACCESS. On a miss, go to ERR.
  - ACCESS:
    - o_slv_p_sel[idx] = i_p_sel. The select is driven from the registered index, so a slave sees sel one cycle after upstream.
    - Timeout counter increments each cycle.
    - If i_slv_p_rdy[idx]=1: capture i_slv_p_rdata[idx] into o_p_rdata, pulse o_p_rdy with o_p_err=0, go to WAIT_REL.
    - Else if counter == TIMEOUT-1: pulse o_p_rdy with o_p_err=1 and o_p_rdata=ERR_RDATA, increment o_tout_cnt, go to WAIT_REL.
    - rdy and timeout in the same cycle: rdy wins.
    - i_p_sel=0 before completion (abort): go to IDLE with no rdy pulse and no count.
  - ERR: pulse o_p_rdy with o_p_err=1 and o_p_rdata=ERR_RDATA, increment o_miss_cnt, go to WAIT_REL. Miss latency is 2 cycles from sel.
  - WAIT_REL: all o_slv_p_sel are 0 and o_p_rdy is 0. Return to IDLE when i_p_sel=0. Back-to-back accesses therefore need one sel-low cycle.
- Latency: slave rdy in cycle t produces o_p_rdy in cycle t+1. o_p_rdy is never high for more than one cycle per access.
- Counters: saturate at 8'hFF and never wrap. Cleared only by reset.
- o_p_rdata holds its last value between responses. o_p_err is 0 whenever o_p_rdy is 0.
- At most one bit of o_slv_p_sel is set at any time.

Test Plan:
1. Read slave 1: addr 16'h9004, slave 1 returns rdy 3 cycles after its sel with rdata 32'h1234_5678 -> single o_p_rdy pulse one cycle later, rdata 32'h1234_5678, err=0, only o_slv_p_sel[1] ever high.
2. Decode miss: addr 16'h3000 -> o_p_rdy two cycles after sel, err=1, rdata 32'hDEAD_BEEF, o_miss_cnt=1, o_slv_p_sel stays 0.
3. Timeout: addr 16'h8000, slave 0 never ready, TIMEOUT=255 -> err pulse 255 cycles into ACCESS, o_slv_p_sel[0] drops, o_tout_cnt=1. Case with rdy arriving in the terminal cycle -> err=0.
4. Abort and reset:
   - Deassert i_p_sel mid-ACCESS -> IDLE, no rdy pulse.
   - Assert i_rst mid-ACCESS -> all outputs 0 immediately.
   - Both cases: the next access completes normally.
5. Saturation and priority:
   - 300 decode misses -> o_miss_cnt=8'hFF.
   - SLV_BASE with duplicate entries at slaves 2 and 3 -> slave 2 selected.
   - Back-to-back writes with one idle cycle between -> each gets exactly one rdy.

Source files
------------

// File: rtl/ips2l_expd_apb_mux_nch.sv
// Table-driven N-slave APB decode mux for the expansion register space.
// One access is tracked at a time. The FSM also handles decode misses and
// timeouts, and keeps a saturating count of each.
module ips2l_expd_apb_mux_nch #(
   parameter int unsigned NUM_SLV   = 4,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEC_MSB   = 15,
   parameter int unsigned DEC_LSB   = 12,
   parameter logic [NUM_SLV*(DEC_MSB-DEC_LSB+1)-1:0] SLV_BASE = {4'hB, 4'hA, 4'h9, 4'h8},
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_p_sel,
   input  logic [DATA_W/8-1:0]         i_p_strb,
   input  logic [ADDR_W-1:0]           i_p_addr,
   input  logic [DATA_W-1:0]           i_p_wdata,
   input  logic                        i_p_ce,
   input  logic                        i_p_we,
   output logic                        o_p_rdy,
   output logic [DATA_W-1:0]           o_p_rdata,
   output logic                        o_p_err,
   output logic [NUM_SLV-1:0]          o_slv_p_sel,
   output logic [DATA_W/8-1:0]         o_slv_p_strb,
   output logic [ADDR_W-1:0]           o_slv_p_addr,
   output logic [DATA_W-1:0]           o_slv_p_wdata,
   output logic                        o_slv_p_ce,
   output logic                        o_slv_p_we,
   input  logic [NUM_SLV-1:0]          i_slv_p_rdy,
   input  logic [NUM_SLV*DATA_W-1:0]   i_slv_p_rdata,
   output logic [7:0]                  o_miss_cnt,
   output logic [7:0]                  o_tout_cnt
);

   localparam int unsigned DW = DEC_MSB - DEC_LSB + 1;
   localparam int unsigned IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, ERR, WAIT_REL} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     idx, idx_nxt, dec_idx;
   logic              dec_hit;
   logic [7:0]        tcnt, tcnt_nxt;
   logic              rdy_nxt, err_nxt, miss_inc, tout_inc;
   logic [DATA_W-1:0] rdata_nxt;
   logic              slv_rdy;
   logic [DATA_W-1:0] slv_rdata;

   // Shared downstream buses are straight copies of the upstream request
   assign o_slv_p_strb  = i_p_strb;
   assign o_slv_p_addr  = i_p_addr;
   assign o_slv_p_wdata = i_p_wdata;
   assign o_slv_p_ce    = i_p_ce;
   assign o_slv_p_we    = i_p_we;

   assign slv_rdy   = i_slv_p_rdy[idx];
   assign slv_rdata = i_slv_p_rdata[idx*DATA_W +: DATA_W];

   // Address decode; scanning downwards lets the lowest matching index win
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
         if (i_p_addr[DEC_MSB:DEC_LSB] == SLV_BASE[k*DW +: DW]) begin
            dec_hit = 1'b1;
            dec_idx = IW'(k);
         end
      end
   end

   // Slave select follows upstream sel, qualified by the registered index
   always_comb begin
      o_slv_p_sel = '0;
      if (state == ACCESS) o_slv_p_sel = NUM_SLV'(i_p_sel) << idx;
   end

   // Next-state and response generation
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      tcnt_nxt  = tcnt;
      rdy_nxt   = 1'b0;
      err_nxt   = 1'b0;
      rdata_nxt = o_p_rdata;
      miss_inc  = 1'b0;
      tout_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (i_p_sel) begin
               idx_nxt   = dec_idx;
               tcnt_nxt  = '0;
               state_nxt = dec_hit ? ACCESS : ERR;
            end
         end
         ACCESS: begin
            tcnt_nxt = tcnt + 8'd1;
            if (!i_p_sel) begin
               state_nxt = IDLE;
            end else if (slv_rdy) begin
               rdy_nxt   = 1'b1;
               rdata_nxt = slv_rdata;
               state_nxt = WAIT_REL;
            end else if (tcnt == 8'(TIMEOUT - 1)) begin
               rdy_nxt   = 1'b1;
               err_nxt   = 1'b1;
               rdata_nxt = ERR_RDATA;
               tout_inc  = 1'b1;
               state_nxt = WAIT_REL;
            end
         end
         ERR: begin
            rdy_nxt   = 1'b1;
            err_nxt   = 1'b1;
            rdata_nxt = ERR_RDATA;
            miss_inc  = 1'b1;
            state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            if (!i_p_sel) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, index and timeout counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         idx   <= '0;
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   // Registered response and saturating error counters
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_p_rdy    <= 1'b0;
         o_p_err    <= 1'b0;
         o_p_rdata  <= '0;
         o_miss_cnt <= '0;
         o_tout_cnt <= '0;
      end else begin
         o_p_rdy   <= rdy_nxt;
         o_p_err   <= err_nxt;
         o_p_rdata <= rdata_nxt;
         if (miss_inc && (o_miss_cnt != 8'hFF)) o_miss_cnt <= o_miss_cnt + 8'd1;
         if (tout_inc && (o_tout_cnt != 8'hFF)) o_tout_cnt <= o_tout_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ips2l_expd_apb_mux_nch.sv
// Self-checking bench for ips2l_expd_apb_mux_nch.
// The bench builds its decode table with slaves 2 and 3 sharing a base.
module tb_ips2l_expd_apb_mux_nch;

   localparam int unsigned NS = 4;
   localparam int unsigned DWD = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             p_sel = 1'b0;
   logic [3:0]       p_strb = '0;
   logic [15:0]      p_addr = '0;
   logic [31:0]      p_wdata = '0;
   logic             p_ce = 1'b0;
   logic             p_we = 1'b0;
   logic             p_rdy;
   logic [31:0]      p_rdata;
   logic             p_err;
   logic [NS-1:0]    slv_sel;
   logic [3:0]       slv_strb;
   logic [15:0]      slv_addr;
   logic [31:0]      slv_wdata;
   logic             slv_ce;
   logic             slv_we;
   logic [NS-1:0]    slv_rdy;
   logic [NS*DWD-1:0] slv_rdata;
   logic [7:0]       miss_cnt;
   logic [7:0]       tout_cnt;

   int               n_chk = 0;
   int               n_err = 0;
   logic [32:0]      exp_q[$];
   logic [NS-1:0]    allow = '0;
   logic [NS-1:0]    seen = '0;
   logic             prev_rdy = 1'b0;
   int               dly[NS];
   logic [31:0]      rdat[NS];
   int               cnt[NS];
   logic [7:0]       exp_miss = '0;
   logic [7:0]       exp_tout = '0;

   ips2l_expd_apb_mux_nch #(
      .NUM_SLV(NS), .ADDR_W(16), .DATA_W(DWD), .DEC_MSB(15), .DEC_LSB(12),
      .SLV_BASE(16'hAA98), .TIMEOUT(255), .ERR_RDATA(32'hDEAD_BEEF)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_p_sel(p_sel), .i_p_strb(p_strb),
      .i_p_addr(p_addr), .i_p_wdata(p_wdata), .i_p_ce(p_ce), .i_p_we(p_we),
      .o_p_rdy(p_rdy), .o_p_rdata(p_rdata), .o_p_err(p_err),
      .o_slv_p_sel(slv_sel), .o_slv_p_strb(slv_strb), .o_slv_p_addr(slv_addr),
      .o_slv_p_wdata(slv_wdata), .o_slv_p_ce(slv_ce), .o_slv_p_we(slv_we),
      .i_slv_p_rdy(slv_rdy), .i_slv_p_rdata(slv_rdata),
      .o_miss_cnt(miss_cnt), .o_tout_cnt(tout_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave models: rdy asserted dly[k] cycles after sel rises (dly < 0: never)
   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) cnt[k] <= slv_sel[k] ? cnt[k] + 1 : 0;
   end

   always_comb begin
      for (int k = 0; k < NS; k++) begin
         slv_rdy[k] = slv_sel[k] && (dly[k] >= 0) && (cnt[k] == dly[k]);
         slv_rdata[k*DWD +: DWD] = rdat[k];
      end
   end

   // Monitor: scoreboard pop on each response plus select sanity
   always @(negedge clk) begin
      if (!rst) begin
         seen <= seen | slv_sel;
         if (slv_sel != '0) begin
            check("sel_onehot", 64'($onehot0(slv_sel)), 64'd1);
            check("sel_illegal", 64'(slv_sel & ~allow), 64'd0);
         end
         if (!p_rdy && p_err) check("err_without_rdy", 64'(p_err), 64'd0);
         if (p_rdy && prev_rdy) check("rdy_two_cycles", 64'(p_rdy), 64'd0);
         if (p_rdy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("rdata", 64'(p_rdata), 64'(e[31:0]));
               check("err", 64'(p_err), 64'(e[32]));
            end
         end
         prev_rdy <= p_rdy;
      end else begin
         prev_rdy <= 1'b0;
      end
   end

   // One complete access; sel held one extra cycle after rdy, then released
   task automatic run_access(input logic [15:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [NS-1:0] mask, input logic [31:0] erd, input logic eerr,
                             input int elat, input logic is_miss, input logic is_tout);
      int  lat;
      logic got;
      @(negedge clk);
      seen    = '0;
      p_addr  = addr;
      p_we    = we;
      p_wdata = wdata;
      p_strb  = 4'hF;
      p_ce    = 1'b1;
      p_sel   = 1'b1;
      allow   = mask;
      exp_q.push_back({eerr, erd});
      lat = 0;
      got = 1'b0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         if (p_rdy) got = 1'b1;
      end
      check("rdy_seen", 64'(got), 64'd1);
      if (!got) exp_q.delete();
      check("latency", 64'(lat), 64'(elat));
      check("wdata_bus", 64'(slv_wdata), 64'(wdata));
      check("we_bus", 64'(slv_we), 64'(we));
      if (is_miss && exp_miss != 8'hFF) exp_miss = exp_miss + 8'd1;
      if (is_tout && exp_tout != 8'hFF) exp_tout = exp_tout + 8'd1;
      check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
      check("tout_cnt", 64'(tout_cnt), 64'(exp_tout));
      @(negedge clk);
      check("sel_in_wait_rel", 64'(slv_sel), 64'd0);
      check("sel_seen", 64'(seen), 64'(mask));
      p_sel = 1'b0;
      p_ce  = 1'b0;
      allow = '0;
   endtask

   initial begin
      dly[0] = -1; dly[1] = 3; dly[2] = 1; dly[3] = 0;
      rdat[0] = 32'h0A0A_0A0A; rdat[1] = 32'h1234_5678;
      rdat[2] = 32'h2222_2222; rdat[3] = 32'h3333_3333;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdy", 64'(p_rdy), 64'd0);
      check("rst_err", 64'(p_err), 64'd0);
      check("rst_rdata", 64'(p_rdata), 64'd0);
      check("rst_sel", 64'(slv_sel), 64'd0);
      check("rst_miss", 64'(miss_cnt), 64'd0);
      check("rst_tout", 64'(tout_cnt), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Read slave 1, rdy 3 cycles after its sel
      run_access(16'h9004, 1'b0, 32'h0, 4'b0010, 32'h1234_5678, 1'b0, 5, 1'b0, 1'b0);
      // Decode miss
      run_access(16'h3000, 1'b0, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 2, 1'b1, 1'b0);
      // Timeout on slave 0
      run_access(16'h8000, 1'b0, 32'h0, 4'b0001, 32'hDEAD_BEEF, 1'b1, 256, 1'b0, 1'b1);
      // rdy in the terminal timeout cycle wins
      dly[0] = 254;
      run_access(16'h8000, 1'b0, 32'h0, 4'b0001, 32'h0A0A_0A0A, 1'b0, 256, 1'b0, 1'b0);
      dly[0] = -1;

      // Abort mid-ACCESS: no response, no count
      @(negedge clk);
      p_addr = 16'h8000; p_sel = 1'b1; p_ce = 1'b1; allow = 4'b0001;
      repeat (4) @(negedge clk);
      check("abort_sel_active", 64'(slv_sel), 64'd1);
      p_sel = 1'b0; p_ce = 1'b0;
      repeat (5) @(negedge clk);
      allow = '0;
      check("abort_tout_cnt", 64'(tout_cnt), 64'(exp_tout));
      run_access(16'h9004, 1'b0, 32'h0, 4'b0010, 32'h1234_5678, 1'b0, 5, 1'b0, 1'b0);

      // Reset mid-ACCESS drops selects asynchronously
      @(negedge clk);
      p_addr = 16'h8000; p_sel = 1'b1; p_ce = 1'b1; allow = 4'b0001;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_sel", 64'(slv_sel), 64'd0);
      check("arst_rdy", 64'(p_rdy), 64'd0);
      check("arst_rdata", 64'(p_rdata), 64'd0);
      check("arst_miss", 64'(miss_cnt), 64'd0);
      check("arst_tout", 64'(tout_cnt), 64'd0);
      exp_miss = '0; exp_tout = '0;
      @(negedge clk);
      p_sel = 1'b0; p_ce = 1'b0; allow = '0;
      @(negedge clk);
      rst = 1'b0;
      run_access(16'h9004, 1'b0, 32'h0, 4'b0010, 32'h1234_5678, 1'b0, 5, 1'b0, 1'b0);

      // Duplicate base at slaves 2 and 3: slave 2 wins
      run_access(16'hA010, 1'b0, 32'h0, 4'b0100, 32'h2222_2222, 1'b0, 3, 1'b0, 1'b0);

      // Back-to-back writes with a single sel-low cycle between them
      run_access(16'h9008, 1'b1, 32'hCAFE_0001, 4'b0010, 32'h1234_5678, 1'b0, 5, 1'b0, 1'b0);
      run_access(16'h900C, 1'b1, 32'hCAFE_0002, 4'b0010, 32'h1234_5678, 1'b0, 5, 1'b0, 1'b0);

      // Miss counter saturation
      for (int i = 0; i < 300; i++)
         run_access(16'h3000, 1'b0, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 2, 1'b1, 1'b0);
      check("miss_saturated", 64'(miss_cnt), 64'hFF);

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
